adjust_field_ctrl: RTL and testbench

//   Parametrised adjust-mode controller for the alarm clock: generalised successor of the fixed 5-field adjust FSM.

---
 rtl/adjust_field_ctrl.sv | 111 +++++++++++
 tb/tb_adjust_field_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adjust_field_ctrl.sv
// adjust_field_ctrl: run/adjust mode controller; one-hot field select, inc/dec pulses, wrap, timeout.
// Optional hold-to-repeat for U/D is built when AUTO_REPEAT_EN is defined.
module adjust_field_ctrl #(
  parameter int NUM_FIELDS    = 5,
  parameter int START_FIELD   = 0,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_RATE   = 100,
  localparam int IDX_W = (NUM_FIELDS > 2) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic                  btn_l_i,
  input  logic                  btn_r_i,
  input  logic                  btn_c_i,
  input  logic                  btn_u_i,
  input  logic                  btn_d_i,
  output logic                  adjust_o,
  output logic [NUM_FIELDS-1:0] field_en_o,
  output logic [IDX_W-1:0]      field_idx_o,
  output logic                  inc_o,
  output logic                  dec_o
);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_FIELDS - 1);
  localparam logic [IDX_W-1:0] START = IDX_W'(START_FIELD);
  localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

  typedef enum logic {RUN, ADJ} state_e;
  state_e state_q, state_d;
  logic [4:0] hist_q;
  logic p_c, p_l, p_r, p_u, p_d, any_press, held, in_adj, mv, timeout, rpt;
  logic [TW-1:0] to_q, to_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_FIELDS-1:0] en_q, en_d;
  logic inc_q, inc_d, dec_q, dec_d;

  assign {p_c, p_l, p_r, p_u, p_d} = {btn_c_i, btn_l_i, btn_r_i, btn_u_i, btn_d_i} & ~hist_q;
  assign any_press = p_c | p_l | p_r | p_u | p_d;
  assign held      = btn_u_i | btn_d_i;
  assign in_adj    = (state_q == ADJ);
  assign mv        = p_l ^ p_r;
  // A press or held U/D in the expiring cycle keeps us in ADJUST
  assign timeout   = (TIMEOUT_TICKS != 0) && (to_q == TO_MAX) && !any_press && !held;
  assign to_d      = (!in_adj || any_press || held) ? '0 :
                     (tick_i && to_q != TO_MAX) ? to_q + 1'b1 : to_q;

`ifdef AUTO_REPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW = $clog2(HMAX + 1);
  localparam logic [HW-1:0] H_DLY = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] H_RATE = HW'(REPEAT_RATE);
  logic [HW-1:0] hc_q, hc_d;
  logic rep_q, rep_d, h_clr;
  assign h_clr = !in_adj || !(btn_u_i ^ btn_d_i) || any_press;
  assign rpt   = !h_clr && tick_i && (hc_q + 1'b1 == (rep_q ? H_RATE : H_DLY));
  assign hc_d  = (h_clr || rpt) ? '0 : hc_q + HW'(tick_i);
  assign rep_d = !h_clr && (rpt || rep_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hc_q  <= '0;
      rep_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      rep_q <= rep_d;
    end
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;

  always_comb
    state_d = in_adj ? ((p_c || timeout) ? RUN : ADJ) : (p_c ? ADJ : RUN);

  always_comb begin
    idx_d = !in_adj ? (p_c ? START : idx_q) :
            (p_c || !mv) ? idx_q :
            p_r ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) :
                  ((idx_q == '0) ? LAST : idx_q - 1'b1);
    inc_d = in_adj && !p_c && !mv && ((p_u && !p_d) || (rpt && btn_u_i));
    dec_d = in_adj && !p_c && !mv && ((p_d && !p_u) || (rpt && btn_d_i));
    en_d  = (state_d == ADJ) ? NUM_FIELDS'(1) << idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '0;
      to_q   <= '0;
      idx_q  <= START;
      en_q   <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      hist_q <= {btn_c_i, btn_l_i, btn_r_i, btn_u_i, btn_d_i};
      to_q   <= to_d;
      idx_q  <= idx_d;
      en_q   <= en_d;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
    end

  assign adjust_o    = in_adj;
  assign field_en_o  = en_q;
  assign field_idx_o = idx_q;
  assign inc_o       = inc_q;
  assign dec_o       = dec_q;
endmodule

// File: tb/tb_adjust_field_ctrl.sv
// tb_adjust_field_ctrl: vector table, directed corner sequences and random stimulus vs a reference model.
module tb_adjust_field_ctrl;
  localparam int NF = 5, TO = 10, DLY = 5, RATE = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic adjust_o, inc_o, dec_o;
  logic [NF-1:0] field_en_o;
  logic [2:0] field_idx_o;

  adjust_field_ctrl #(.NUM_FIELDS(NF), .START_FIELD(0), .TIMEOUT_TICKS(TO),
                      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick),
    .btn_l_i(btn_l), .btn_r_i(btn_r), .btn_c_i(btn_c), .btn_u_i(btn_u), .btn_d_i(btn_d),
    .adjust_o(adjust_o), .field_en_o(field_en_o), .field_idx_o(field_idx_o),
    .inc_o(inc_o), .dec_o(dec_o));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit m_adj = 0, e_inc = 0, e_dec = 0;
  int m_idx = 0, m_to = 0, m_hold = 0;
  logic [4:0] m_prev = '0;

  typedef struct {
    logic [4:0] b;
    logic adj;
    logic [4:0] en;
    logic inc, dec;
  } vec_t;
  vec_t tbl[28];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_adj = 0; m_idx = 0; m_to = 0; m_hold = 0; m_prev = '0; e_inc = 0; e_dec = 0;
  endtask

  // b = {c,l,r,u,d}; computes what the outputs must be after this cycle's edge
  task automatic model(input logic [4:0] b, input logic t);
    logic c, l, r, u, d, pc, pl, pr, pu, pd, anyp, one, rep;
    {c, l, r, u, d} = b;
    {pc, pl, pr, pu, pd} = b & ~m_prev;
    m_prev = b;
    anyp = pc | pl | pr | pu | pd;
    e_inc = 0; e_dec = 0;
    if (!m_adj) begin
      if (pc) begin m_adj = 1; m_idx = 0; m_to = 0; m_hold = 0; end
    end else begin
      one = u ^ d;
      if (!one || anyp) m_hold = 0;
      else if (t) m_hold++;
      rep = AUTO && one && !anyp && t && m_hold >= DLY && ((m_hold - DLY) % RATE == 0);
      if (pc) m_adj = 0;
      else if (pl ^ pr) m_idx = pr ? (m_idx + 1) % NF : (m_idx + NF - 1) % NF;
      else if (pu ^ pd) begin e_inc = pu; e_dec = pd; end
      else if (rep) begin e_inc = u; e_dec = d; end
      if (anyp || u || d) m_to = 0;
      else if (m_to == TO) begin m_adj = 0; m_to = 0; end
      else if (t) m_to++;
    end
  endtask

  task automatic step(input logic [4:0] b, input logic t);
    logic [NF-1:0] een;
    @(negedge clk);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
    tick = t;
    @(posedge clk);
    #1;
    model(b, t);
    een = m_adj ? NF'(1) << m_idx : '0;
    check("model", {21'd0, adjust_o, field_en_o, field_idx_o, inc_o, dec_o},
          {21'd0, m_adj, een, 3'(m_idx), e_inc, e_dec});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_held, cnt_after;
    logic [4:0] b;
    tbl[0]  = '{5'b00000, 0, 5'b00000, 0, 0};
    tbl[1]  = '{5'b10000, 1, 5'b00001, 0, 0};
    tbl[2]  = '{5'b00000, 1, 5'b00001, 0, 0};
    tbl[3]  = '{5'b00100, 1, 5'b00010, 0, 0};
    tbl[4]  = '{5'b00000, 1, 5'b00010, 0, 0};
    tbl[5]  = '{5'b00100, 1, 5'b00100, 0, 0};
    tbl[6]  = '{5'b00000, 1, 5'b00100, 0, 0};
    tbl[7]  = '{5'b00100, 1, 5'b01000, 0, 0};
    tbl[8]  = '{5'b00000, 1, 5'b01000, 0, 0};
    tbl[9]  = '{5'b00100, 1, 5'b10000, 0, 0};
    tbl[10] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[11] = '{5'b00100, 1, 5'b00001, 0, 0};
    tbl[12] = '{5'b00000, 1, 5'b00001, 0, 0};
    tbl[13] = '{5'b01000, 1, 5'b10000, 0, 0};
    tbl[14] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[15] = '{5'b01100, 1, 5'b10000, 0, 0};
    tbl[16] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[17] = '{5'b00010, 1, 5'b10000, 1, 0};
    tbl[18] = '{5'b00010, 1, 5'b10000, 0, 0};
    tbl[19] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[20] = '{5'b00011, 1, 5'b10000, 0, 0};
    tbl[21] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[22] = '{5'b00001, 1, 5'b10000, 0, 1};
    tbl[23] = '{5'b00000, 1, 5'b10000, 0, 0};
    tbl[24] = '{5'b10000, 0, 5'b00000, 0, 0};
    tbl[25] = '{5'b00000, 0, 5'b00000, 0, 0};
    tbl[26] = '{5'b00010, 0, 5'b00000, 0, 0};
    tbl[27] = '{5'b00000, 0, 5'b00000, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset", {21'd0, adjust_o, field_en_o, field_idx_o, inc_o, dec_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].b, 1'b0);
      check($sformatf("tbl%0d", i), {24'd0, adjust_o, field_en_o, inc_o, dec_o},
            {24'd0, tbl[i].adj, tbl[i].en, tbl[i].inc, tbl[i].dec});
    end

    // inactivity timeout, restarted by an R press
    step(5'b10000, 1'b0);
    step(5'b00000, 1'b0);
    repeat (9) step(5'b00000, 1'b1);
    step(5'b00100, 1'b0);
    repeat (10) step(5'b00000, 1'b1);
    check("to_still_adj", {31'd0, adjust_o}, 32'd1);
    step(5'b00000, 1'b0);
    check("to_exit", {31'd0, adjust_o}, 32'd0);

    // U held through many ticks
    step(5'b10000, 1'b0);
    step(5'b00000, 1'b0);
    cnt_held = 0;
    cnt_after = 0;
    step(5'b00010, 1'b0);
    cnt_held += int'(inc_o);
    for (int i = 0; i < 10; i++) begin
      step(5'b00010, 1'b1);
      cnt_held += int'(inc_o);
      step(5'b00010, 1'b0);
      cnt_held += int'(inc_o);
    end
    repeat (4) begin
      step(5'b00000, 1'b1);
      cnt_after += int'(inc_o) + int'(dec_o);
    end
    check("hold_pulses", cnt_held, AUTO ? 32'd4 : 32'd1);
    check("release_pulses", cnt_after, 32'd0);

    // asynchronous reset mid-adjust with U held
    step(5'b00000, 1'b0);
    step(5'b00010, 1'b0);
    check("pre_rst_inc", {31'd0, inc_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {28'd0, adjust_o, inc_o, dec_o, |field_en_o}, 32'd0);
    @(negedge clk);
    {btn_c, btn_l, btn_r, btn_u, btn_d} = '0;
    rst_n = 1'b1;
    model_reset();

    // random stimulus against the model
    b = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) b[4] = ~b[4];
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
      step(b, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
